// File: rtl/hc_tx_port_arbiter.sv
// rtl/hc_tx_port_arbiter.sv - three-way HCTxPort arbiter: SOF priority, SP/DC round-robin,
// bounded hold with timeout revocation and an enforced idle gap between owners.
module hc_tx_port_arbiter #(
    parameter int DATA_W   = 8,
    parameter int GAP_CYC  = 1,
    parameter int MAX_HOLD = 1500,
    parameter int HOLD_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              sofReq,
    output logic              sofGnt,
    input  logic              sofWEn,
    input  logic [DATA_W-1:0] sofData,
    input  logic [DATA_W-1:0] sofCntl,

    input  logic              spReq,
    output logic              spGnt,
    input  logic              spWEn,
    input  logic [DATA_W-1:0] spData,
    input  logic [DATA_W-1:0] spCntl,

    input  logic              dcReq,
    output logic              dcGnt,
    input  logic              dcWEn,
    input  logic [DATA_W-1:0] dcData,
    input  logic [DATA_W-1:0] dcCntl,

    output logic              txWEnable,
    output logic [DATA_W-1:0] txData,
    output logic [DATA_W-1:0] txCntl,
    input  logic              txRdyIn,
    output logic              txRdyOut,
    output logic              holdTimeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_SOF = 3'd1,
        GNT_SP  = 3'd2,
        GNT_DC  = 3'd3,
        GAP     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SOF  = 2'd1,
        SEL_SP   = 2'd2,
        SEL_DC   = 2'd3
    } sel_t;

    localparam logic              RR_SP     = 1'b0;
    localparam logic              RR_DC     = 1'b1;
    localparam logic              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYC - 1);

    state_t            state, stateNext;
    sel_t              sel, selNext;
    logic [HOLD_W-1:0] holdCnt, holdCntNext;
    logic [3:0]        gapCnt, gapCntNext;
    logic              rrLast, rrLastNext;
    logic              blockSP, blockSPNext;
    logic              blockDC, blockDCNext;
    logic              timeoutNext;
    logic              spElig, dcElig;

    assign spElig = spReq & ~blockSP;
    assign dcElig = dcReq & ~blockDC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= SEL_NONE;
            holdCnt     <= '0;
            gapCnt      <= '0;
            rrLast      <= RR_DC;
            blockSP     <= 1'b0;
            blockDC     <= 1'b0;
            holdTimeout <= 1'b0;
        end else begin
            state       <= stateNext;
            sel         <= selNext;
            holdCnt     <= holdCntNext;
            gapCnt      <= gapCntNext;
            rrLast      <= rrLastNext;
            blockSP     <= blockSPNext;
            blockDC     <= blockDCNext;
            holdTimeout <= timeoutNext;
        end
    end

    always_comb begin
        stateNext   = state;
        selNext     = sel;
        holdCntNext = holdCnt;
        gapCntNext  = gapCnt;
        rrLastNext  = rrLast;
        timeoutNext = 1'b0;
        // A block lifts as soon as its requester is seen idle.
        blockSPNext = blockSP & spReq;
        blockDCNext = blockDC & dcReq;

        case (state)
            IDLE: begin
                if (sofReq) begin
                    stateNext   = GNT_SOF;
                    selNext     = SEL_SOF;
                    holdCntNext = '0;
                end else if (spElig && (!dcElig || rrLast == RR_DC)) begin
                    stateNext   = GNT_SP;
                    selNext     = SEL_SP;
                    holdCntNext = '0;
                    rrLastNext  = RR_SP;
                end else if (dcElig) begin
                    stateNext   = GNT_DC;
                    selNext     = SEL_DC;
                    holdCntNext = '0;
                    rrLastNext  = RR_DC;
                end
            end

            GNT_SOF: begin
                if (!sofReq) begin
                    stateNext  = GAP;
                    selNext    = SEL_NONE;
                    gapCntNext = '0;
                end
            end

            GNT_SP: begin
                if (!spReq) begin
                    stateNext  = GAP;
                    selNext    = SEL_NONE;
                    gapCntNext = '0;
                end else if (HOLD_EN && holdCnt == HOLD_LAST) begin
                    stateNext   = GAP;
                    selNext     = SEL_NONE;
                    gapCntNext  = '0;
                    timeoutNext = 1'b1;
                    blockSPNext = 1'b1;
                end else begin
                    holdCntNext = holdCnt + 1'b1;
                end
            end

            GNT_DC: begin
                if (!dcReq) begin
                    stateNext  = GAP;
                    selNext    = SEL_NONE;
                    gapCntNext = '0;
                end else if (HOLD_EN && holdCnt == HOLD_LAST) begin
                    stateNext   = GAP;
                    selNext     = SEL_NONE;
                    gapCntNext  = '0;
                    timeoutNext = 1'b1;
                    blockDCNext = 1'b1;
                end else begin
                    holdCntNext = holdCnt + 1'b1;
                end
            end

            GAP: begin
                selNext = SEL_NONE;
                if (gapCnt == GAP_LAST) begin
                    stateNext  = IDLE;
                    gapCntNext = '0;
                end else begin
                    gapCntNext = gapCnt + 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                selNext   = SEL_NONE;
            end
        endcase
    end

    // Grants decode straight from the registered select so they can never disagree.
    assign sofGnt = (sel == SEL_SOF);
    assign spGnt  = (sel == SEL_SP);
    assign dcGnt  = (sel == SEL_DC);

    always_comb begin
        txWEnable = 1'b0;
        txData    = '0;
        txCntl    = '0;
        case (sel)
            SEL_SOF: begin
                txWEnable = sofWEn;
                txData    = sofData;
                txCntl    = sofCntl;
            end
            SEL_SP: begin
                txWEnable = spWEn;
                txData    = spData;
                txCntl    = spCntl;
            end
            SEL_DC: begin
                txWEnable = dcWEn;
                txData    = dcData;
                txCntl    = dcCntl;
            end
            default: begin
                txWEnable = 1'b0;
                txData    = '0;
                txCntl    = '0;
            end
        endcase
    end

    assign txRdyOut = txRdyIn;

endmodule

// File: tb/tb_hc_tx_port_arbiter.sv
// tb/tb_hc_tx_port_arbiter.sv - directed-vector bench for hc_tx_port_arbiter.
module tb_hc_tx_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sofReq, sofGnt, sofWEn;
    logic [7:0] sofData, sofCntl;
    logic       spReq, spGnt, spWEn;
    logic [7:0] spData, spCntl;
    logic       dcReq, dcGnt, dcWEn;
    logic [7:0] dcData, dcCntl;
    logic       txWEnable;
    logic [7:0] txData, txCntl;
    logic       txRdyIn, txRdyOut, holdTimeout;

    int nCompared   = 0;
    int nMismatched = 0;

    hc_tx_port_arbiter #(
        .DATA_W  (8),
        .GAP_CYC (1),
        .MAX_HOLD(8),
        .HOLD_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sofReq     (sofReq),
        .sofGnt     (sofGnt),
        .sofWEn     (sofWEn),
        .sofData    (sofData),
        .sofCntl    (sofCntl),
        .spReq      (spReq),
        .spGnt      (spGnt),
        .spWEn      (spWEn),
        .spData     (spData),
        .spCntl     (spCntl),
        .dcReq      (dcReq),
        .dcGnt      (dcGnt),
        .dcWEn      (dcWEn),
        .dcData     (dcData),
        .dcCntl     (dcCntl),
        .txWEnable  (txWEnable),
        .txData     (txData),
        .txCntl     (txCntl),
        .txRdyIn    (txRdyIn),
        .txRdyOut   (txRdyOut),
        .holdTimeout(holdTimeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sofReq = 1'b1; spReq = 1'b1; dcReq = 1'b1;
        sofWEn = 1'b1; sofData = 8'h11; sofCntl = 8'h22;
        spWEn = 1'b1;  spData = 8'h33;  spCntl = 8'h44;
        dcWEn = 1'b1;  dcData = 8'h55;  dcCntl = 8'h66;
        txRdyIn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nCompared++;
            if ({sofGnt, spGnt, dcGnt} !== 3'b000) begin
                nMismatched++;
                $display("FAIL reset_gnt cyc%0d: got %b want 000", i, {sofGnt, spGnt, dcGnt});
            end
            nCompared++;
            if (txWEnable !== 1'b0 || txData !== 8'h00) begin
                nMismatched++;
                $display("FAIL reset_tx cyc%0d: got wen=%b data=%h want 0/00", i, txWEnable, txData);
            end
            nCompared++;
            if (holdTimeout !== 1'b0) begin
                nMismatched++;
                $display("FAIL reset_timeout: got %b want 0", holdTimeout);
            end
        end
        rst = 1'b0;
        #1;
        nCompared++;
        if (sofGnt !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_idle_cycle: sofGnt got %b want 0", sofGnt);
        end
        tick();
        nCompared++;
        if ({sofGnt, spGnt, dcGnt} !== 3'b100) begin
            nMismatched++;
            $display("FAIL reset_first_grant: got %b want 100", {sofGnt, spGnt, dcGnt});
        end
        nCompared++;
        if (txWEnable !== 1'b1 || txData !== 8'h11 || txCntl !== 8'h22) begin
            nMismatched++;
            $display("FAIL reset_sof_mux: got %b/%h/%h want 1/11/22", txWEnable, txData, txCntl);
        end
    endtask

    // Continues from test_reset: SOF owns the port, SP and DC still requesting.
    task automatic test_priority();
        logic [2:0] expSeq [4];
        expSeq[0] = 3'b000;
        expSeq[1] = 3'b000;
        expSeq[2] = 3'b010;
        expSeq[3] = 3'b010;
        tick();
        nCompared++;
        if ({sofGnt, spGnt, dcGnt} !== 3'b100) begin
            nMismatched++;
            $display("FAIL prio_sof_hold: got %b want 100", {sofGnt, spGnt, dcGnt});
        end
        sofReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nCompared++;
            if ({sofGnt, spGnt, dcGnt} !== expSeq[i]) begin
                nMismatched++;
                $display("FAIL prio_seq step%0d: got %b want %b", i, {sofGnt, spGnt, dcGnt}, expSeq[i]);
            end
        end
        spReq = 1'b0; dcReq = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        do_reset();
        sofReq = 1'b0; spReq = 1'b1; dcReq = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            want = (g % 2 == 0) ? 3'b010 : 3'b001;
            for (int c = 0; c < 4; c++) begin
                nCompared++;
                if ({sofGnt, spGnt, dcGnt} !== want) begin
                    nMismatched++;
                    $display("FAIL rr grant%0d cyc%0d: got %b want %b", g, c, {sofGnt, spGnt, dcGnt}, want);
                end
                if (c < 3) tick();
            end
            if (want == 3'b010) spReq = 1'b0; else dcReq = 1'b0;
            tick();
            nCompared++;
            if ({sofGnt, spGnt, dcGnt} !== 3'b000) begin
                nMismatched++;
                $display("FAIL rr gap%0d: got %b want 000", g, {sofGnt, spGnt, dcGnt});
            end
            spReq = 1'b1; dcReq = 1'b1;
            tick();
            nCompared++;
            if ({sofGnt, spGnt, dcGnt} !== 3'b000) begin
                nMismatched++;
                $display("FAIL rr idle%0d: got %b want 000", g, {sofGnt, spGnt, dcGnt});
            end
            tick();
        end
        spReq = 1'b0; dcReq = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_mux();
        do_reset();
        spReq = 1'b1;
        tick();
        spWEn = 1'b1; spData = 8'hA5; spCntl = 8'h03;
        dcWEn = 1'b1; dcData = 8'h5A; dcCntl = 8'hFF;
        #1;
        nCompared++;
        if (spGnt !== 1'b1 || txData !== 8'hA5 || txCntl !== 8'h03 || txWEnable !== 1'b1) begin
            nMismatched++;
            $display("FAIL mux_sp: got gnt=%b data=%h cntl=%h wen=%b want 1/a5/03/1",
                     spGnt, txData, txCntl, txWEnable);
        end
        spWEn = 1'b0;
        #1;
        nCompared++;
        if (txWEnable !== 1'b0) begin
            nMismatched++;
            $display("FAIL mux_nonowner_wen: got %b want 0", txWEnable);
        end
        txRdyIn = 1'b1;
        #1;
        nCompared++;
        if (txRdyOut !== 1'b1) begin
            nMismatched++;
            $display("FAIL rdy_pass_hi: got %b want 1", txRdyOut);
        end
        txRdyIn = 1'b0;
        #1;
        nCompared++;
        if (txRdyOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL rdy_pass_lo: got %b want 0", txRdyOut);
        end
        spReq = 1'b0;
        tick();
        nCompared++;
        if (txWEnable !== 1'b0 || txData !== 8'h00 || txCntl !== 8'h00) begin
            nMismatched++;
            $display("FAIL mux_none: got %b/%h/%h want 0/00/00", txWEnable, txData, txCntl);
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        int gntCycles = 0;
        int pulses    = 0;
        int lastGnt   = -1;
        int pulseAt   = -1;
        do_reset();
        dcReq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dcGnt) begin gntCycles++; lastGnt = i; end
            if (holdTimeout) begin pulses++; pulseAt = i; end
        end
        nCompared++;
        if (gntCycles != 8) begin
            nMismatched++;
            $display("FAIL timeout_hold_len: got %0d want 8", gntCycles);
        end
        nCompared++;
        if (pulses != 1) begin
            nMismatched++;
            $display("FAIL timeout_pulses: got %0d want 1", pulses);
        end
        nCompared++;
        if (pulseAt != lastGnt + 1) begin
            nMismatched++;
            $display("FAIL timeout_pulse_pos: got %0d want %0d", pulseAt, lastGnt + 1);
        end
        dcReq = 1'b0;
        tick();
        nCompared++;
        if (dcGnt !== 1'b0) begin
            nMismatched++;
            $display("FAIL timeout_blocked: got %b want 0", dcGnt);
        end
        dcReq = 1'b1;
        tick();
        nCompared++;
        if (dcGnt !== 1'b1) begin
            nMismatched++;
            $display("FAIL timeout_regrant: got %b want 1", dcGnt);
        end
        dcReq = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_no_preempt_reset();
        do_reset();
        spReq = 1'b1;
        tick();
        sofReq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nCompared++;
            if ({sofGnt, spGnt, dcGnt} !== 3'b010) begin
                nMismatched++;
                $display("FAIL nopreempt cyc%0d: got %b want 010", i, {sofGnt, spGnt, dcGnt});
            end
        end
        spReq = 1'b0;
        tick(); tick(); tick();
        sofWEn = 1'b1;
        #1;
        nCompared++;
        if (sofGnt !== 1'b1 || txWEnable !== 1'b1) begin
            nMismatched++;
            $display("FAIL sof_after_sp: got gnt=%b wen=%b want 1/1", sofGnt, txWEnable);
        end
        rst = 1'b1;
        tick();
        nCompared++;
        if (sofGnt !== 1'b0 || txWEnable !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_midop: got gnt=%b wen=%b want 0/0", sofGnt, txWEnable);
        end
        rst = 1'b0;
        sofReq = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_round_robin();
        test_mux();
        test_timeout();
        test_no_preempt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
